// File: rtl/cla_ctrl_pkg.sv
// Shared definitions for the CLA accumulator controller: FSM state encoding and default counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cla_ctrl_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    WAIT = 3'd2,
    ADD  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/cla_accum_ctrl_if.sv
// Bus between the accumulation controller and its datapath/requester.
// Latency: n/a (wiring only).
// Backpressure: in_ready/in_valid handshake on operands; start is accepted only while busy is low.
// Ports: job request (start, num_ops), operand handshake (in_valid, in_ready), carry-out (cout),
//        datapath enables (ld_op, ld_acc, clr_acc) and status (busy, done, overflow).
interface cla_accum_ctrl_if #(
  parameter int CNT_W = cla_ctrl_pkg::CNT_W_DEF
);
  logic             start;
  logic [CNT_W-1:0] num_ops;
  logic             in_valid;
  logic             cout;
  logic             in_ready;
  logic             ld_op;
  logic             ld_acc;
  logic             clr_acc;
  logic             busy;
  logic             done;
  logic             overflow;

  // Requester/datapath side.
  modport master (
    output start, num_ops, in_valid, cout,
    input  in_ready, ld_op, ld_acc, clr_acc, busy, done, overflow
  );

  // Controller side.
  modport slave (
    input  start, num_ops, in_valid, cout,
    output in_ready, ld_op, ld_acc, clr_acc, busy, done, overflow
  );
endinterface

// File: rtl/cla_accum_ctrl_op_down_counter.sv
// Remaining-operand down counter with zero/one flags for the accumulation FSM.
// Latency: load/dec take effect at the next rising edge; flags are combinational from the count.
// Backpressure: none; dec is ignored at zero so the count can never wrap.
// Ports: clk, clear (sync, active-high), load + load_val, dec, zero, one.
module op_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == W'(1));

endmodule

// File: rtl/cla_accum_ctrl.sv
// Sequencing controller for a CLA accumulator: clears the accumulator, then loads and adds num_ops operands.
// Latency: start in cycle 0 -> done in cycle 2+2*num_ops; at most one operand per 2 cycles.
// Backpressure: waits in WAIT with in_ready=1 until in_valid; start ignored while busy.
// Ports: clk, clear (sync, active-high, highest priority), bus (slave side of cla_accum_ctrl_if).
module cla_accum_ctrl
  import cla_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic             clk,
  input logic             clear,
  cla_accum_ctrl_if.slave bus
);

  state_t state, state_nxt;
  logic   ovf_q;
  logic   rem_zero, rem_one;
  logic   job_accept;

  assign job_accept = (state == IDLE) && bus.start;

  op_down_counter #(.W(CNT_W)) u_remaining (
    .clk      (clk),
    .clear    (clear),
    .load     (job_accept),
    .load_val (bus.num_ops),
    .dec      (state == ADD),
    .zero     (rem_zero),
    .one      (rem_one)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // Cleared on the edge that enters INIT, so the flag already reads 0
      // throughout INIT while the previous job's value survives in IDLE.
      if (job_accept) begin
        ovf_q <= 1'b0;
      end else if (state == ADD) begin
        ovf_q <= ovf_q | bus.cout;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.ld_op    = 1'b0;
    bus.ld_acc   = 1'b0;
    bus.clr_acc  = 1'b0;
    bus.busy     = (state != IDLE);
    bus.done     = 1'b0;
    bus.overflow = ovf_q;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = INIT;
      end
      INIT: begin
        bus.clr_acc = 1'b1;
        state_nxt   = rem_zero ? DONE : WAIT;
      end
      WAIT: begin
        bus.in_ready = 1'b1;
        bus.ld_op    = bus.in_valid;
        if (bus.in_valid) state_nxt = ADD;
      end
      ADD: begin
        bus.ld_acc = 1'b1;
        // Counter still holds the pre-decrement value here.
        state_nxt  = rem_one ? DONE : WAIT;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
